// File: rtl/d_cache_fm_ctrl.sv
// d_cache_fm_ctrl
// Far-memory controller behind the data cache. It accepts line fills and
// dirty evictions into a small in-order queue. A serial engine then services
// each queued request against a 2**FM_ADRS_W x 128-bit backing store. Every
// operation takes a fixed latency.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   fm_req_opcode [1:0]      00 none, 01 fill, 10 dirty evict, 11 reserved
//   fm_req_address [27:0]    cache-line address
//   fm_req_data [127:0]      evicted line (dirty evict only)
//   fm_req_tq_id [2:0]       cache transaction id, echoed on fill responses
//   fm_ready                 queue not full; request is captured when high
//   fm_rsp_valid             single-cycle fill response strobe
//   fm_rsp_address/data/tq_id  fill response payload
//   fm_busy                  queue non-empty or engine active
//   fm_err                   sticky: reserved opcode seen since reset
module d_cache_fm_ctrl #(
  parameter int FM_ADRS_W  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int FM_LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   fm_req_opcode,
  input  logic [27:0]  fm_req_address,
  input  logic [127:0] fm_req_data,
  input  logic [2:0]   fm_req_tq_id,
  output logic         fm_ready,
  output logic         fm_rsp_valid,
  output logic [27:0]  fm_rsp_address,
  output logic [127:0] fm_rsp_data,
  output logic [2:0]   fm_rsp_tq_id,
  output logic         fm_busy,
  output logic         fm_err
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int COUNT_W = PTR_W + 1;
  localparam int CNT_W   = (FM_LATENCY > 2) ? $clog2(FM_LATENCY) : 1;
  localparam int LINES   = 2 ** FM_ADRS_W;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_FILL  = 2'b01,
    OP_EVICT = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  typedef struct packed {
    op_e          opcode;
    logic [27:0]  address;
    logic [127:0] data;
    logic [2:0]   tq_id;
  } req_t;

  // ---------------------------------------------------------------------------
  // Request queue
  // ---------------------------------------------------------------------------
  req_t               fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [COUNT_W-1:0] count;
  logic               full;
  logic               empty;
  logic               req_valid;
  logic               push;
  logic               pop;

  state_e             state_q;
  state_e             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  req_t               op_q;

  assign full      = (count == COUNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign req_valid = (fm_req_opcode == OP_FILL) || (fm_req_opcode == OP_EVICT);
  assign push      = req_valid && !full;
  // The engine takes the head only when idle, so fm_ready never sees a pop.
  assign pop       = (state_q == S_IDLE) && !empty;
  assign fm_ready  = !full;
  assign fm_busy   = !empty || (state_q != S_IDLE);

  // NOTE: storage arrays carry no reset; the pointers and count alone define
  // which entries are valid, and resetting wide arrays costs routing for nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{opcode:  op_e'(fm_req_opcode),
                            address: fm_req_address,
                            data:    fm_req_data,
                            tq_id:   fm_req_tq_id};
    end
  end

  // NOTE: every sequential block uses non-blocking assignments so all
  // registers update from the same pre-edge values, matching the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Engine FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pop) op_q <= fifo_mem[rd_ptr];
    end
  end

  // NOTE: defaults are assigned before the case so every path drives every
  // output, which keeps this block purely combinational (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(FM_LATENCY - 2);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Backing store and response
  // ---------------------------------------------------------------------------
  logic [127:0]         store [LINES];
  logic [FM_ADRS_W-1:0] line_idx;
  logic                 rsp_fire;
  logic                 store_we;

  // Upper address bits are dropped, so aliasing lines share one entry.
  assign line_idx = op_q.address[FM_ADRS_W-1:0];
  // The fill response is registered on the WAIT->DONE edge, so the strobe is
  // high during DONE.
  assign rsp_fire = (state_q == S_WAIT) && (cnt_q == '0) && (op_q.opcode == OP_FILL);
  assign store_we = (state_q == S_DONE) && (op_q.opcode == OP_EVICT) && !rst;

  always_ff @(posedge clk) begin
    if (store_we) store[line_idx] <= op_q.data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fm_rsp_valid   <= 1'b0;
      fm_rsp_address <= '0;
      fm_rsp_data    <= '0;
      fm_rsp_tq_id   <= '0;
    end else begin
      fm_rsp_valid <= rsp_fire;
      if (rsp_fire) begin
        fm_rsp_address <= op_q.address;
        fm_rsp_data    <= store[line_idx];
        fm_rsp_tq_id   <= op_q.tq_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                fm_err <= 1'b0;
    else if (fm_req_opcode == OP_RSVD)      fm_err <= 1'b1;
  end

endmodule

// File: tb/tb_d_cache_fm_ctrl.sv
module tb_d_cache_fm_ctrl;

  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   fm_req_opcode;
  logic [27:0]  fm_req_address;
  logic [127:0] fm_req_data;
  logic [2:0]   fm_req_tq_id;
  logic         fm_ready;
  logic         fm_rsp_valid;
  logic [27:0]  fm_rsp_address;
  logic [127:0] fm_rsp_data;
  logic [2:0]   fm_rsp_tq_id;
  logic         fm_busy;
  logic         fm_err;

  d_cache_fm_ctrl #(.FM_ADRS_W(8), .FIFO_DEPTH(4), .FM_LATENCY(L)) dut (
    .clk            (clk),
    .rst            (rst),
    .fm_req_opcode  (fm_req_opcode),
    .fm_req_address (fm_req_address),
    .fm_req_data    (fm_req_data),
    .fm_req_tq_id   (fm_req_tq_id),
    .fm_ready       (fm_ready),
    .fm_rsp_valid   (fm_rsp_valid),
    .fm_rsp_address (fm_rsp_address),
    .fm_rsp_data    (fm_rsp_data),
    .fm_rsp_tq_id   (fm_rsp_tq_id),
    .fm_busy        (fm_busy),
    .fm_err         (fm_err)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] NOP = 2'b00, FILL = 2'b01, EVICT = 2'b10, RSVD = 2'b11;

  // Posedge count: after edge k has occurred, cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc++;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [27:0]  addr;
    logic [127:0] data;
    logic [2:0]   tq;
    int           cyc;
  } exp_t;
  exp_t sb[$];

  // Timing model: edge at which the engine can next take a queue entry.
  int next_pop     = 0;
  int last_rsp_cyc = -1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (fm_rsp_valid === 1'b1) begin
      last_rsp_cyc = cyc;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp: got response addr %h tq %0d at cycle %0d expected none",
                 fm_rsp_address, fm_rsp_tq_id, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_address", fm_rsp_address, e.addr);
        check("rsp_data",    fm_rsp_data,    e.data);
        check("rsp_tq_id",   fm_rsp_tq_id,   e.tq);
        check("rsp_cycle",   cyc,            e.cyc);
      end
    end
  end

  // Entered just after a negedge; returns just after the negedge that follows
  // the accepting edge, with the opcode back to NO_REQ.
  task automatic send(input logic [1:0] op, input logic [27:0] a, input logic [127:0] d,
                      input logic [2:0] id, input logic [27:0] ea, input logic [127:0] ed,
                      output int acc);
    int budget = 0;
    int pop_edge;
    fm_req_opcode  = op;
    fm_req_address = a;
    fm_req_data    = d;
    fm_req_tq_id   = id;
    while (fm_ready !== 1'b1 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (fm_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got fm_ready low for %0d cycles expected acceptance", budget);
      fm_req_opcode = NOP;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    pop_edge = (acc + 1 > next_pop) ? acc + 1 : next_pop;
    next_pop = pop_edge + L + 1;
    if (op == FILL) sb.push_back('{addr: ea, data: ed, tq: id, cyc: pop_edge + L - 1});
    @(negedge clk);
    fm_req_opcode = NOP;
  endtask

  task automatic drain();
    int budget = 0;
    while ((sb.size() != 0 || fm_busy !== 1'b0) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() != 0 || fm_busy !== 1'b0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d responses outstanding busy %b expected 0 and 0",
               sb.size(), fm_busy);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"},     fm_ready,       1'b1);
    check({tag, "_rsp_valid"}, fm_rsp_valid,   1'b0);
    check({tag, "_rsp_addr"},  fm_rsp_address, 28'h0);
    check({tag, "_rsp_data"},  fm_rsp_data,    128'h0);
    check({tag, "_rsp_tq"},    fm_rsp_tq_id,   3'h0);
    check({tag, "_busy"},      fm_busy,        1'b0);
    check({tag, "_err"},       fm_err,         1'b0);
  endtask

  function automatic logic [127:0] pat(input int i);
    logic [31:0] w;
    w = 32'hB000_0000 + 32'(i);
    return {4{w}};
  endfunction

  typedef struct {
    logic [1:0]   op;
    logic [27:0]  addr;
    logic [127:0] data;
    logic [2:0]   tq;
    logic [27:0]  exp_addr;
    logic [127:0] exp_data;
  } vec_t;

  localparam logic [127:0] D_DEAD = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] D_A    = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] D_B    = 128'h55555555_AAAAAAAA_12121212_34343434;
  localparam logic [127:0] D_C    = 128'h0BAD0BAD_0BAD0BAD_0BAD0BAD_0BAD0BAD;
  localparam logic [127:0] D_E    = 128'hF0F0F0F0_0F0F0F0F_C3C3C3C3_3C3C3C3C;

  initial begin
    vec_t tbl[10];
    int acc;

    tbl[0] = '{EVICT, 28'h0000012, D_DEAD, 3'd0, 28'h0,       128'h0};
    tbl[1] = '{FILL,  28'h0000012, 128'h0, 3'd5, 28'h0000012, D_DEAD};
    tbl[2] = '{EVICT, 28'h0000103, D_A,    3'd0, 28'h0,       128'h0};
    tbl[3] = '{FILL,  28'h0000003, 128'h0, 3'd2, 28'h0000003, D_A};
    tbl[4] = '{FILL,  28'h0000103, 128'h0, 3'd1, 28'h0000103, D_A};
    tbl[5] = '{EVICT, 28'h0000005, D_B,    3'd0, 28'h0,       128'h0};
    tbl[6] = '{FILL,  28'h0000005, 128'h0, 3'd3, 28'h0000005, D_B};
    tbl[7] = '{EVICT, 28'h0000012, D_E,    3'd0, 28'h0,       128'h0};
    tbl[8] = '{FILL,  28'h0000012, 128'h0, 3'd6, 28'h0000012, D_E};
    tbl[9] = '{FILL,  28'hFFFFF12, 128'h0, 3'd7, 28'hFFFFF12, D_E};

    rst            = 1'b1;
    fm_req_opcode  = NOP;
    fm_req_address = '0;
    fm_req_data    = '0;
    fm_req_tq_id   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");

    // Table: evict/fill pairs, aliasing and overwrite, issued back to back.
    for (int i = 0; i < 10; i++)
      send(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].tq, tbl[i].exp_addr, tbl[i].exp_data, acc);
    drain();

    // Latency on an idle controller.
    repeat (3) @(negedge clk);
    send(FILL, 28'h0000012, 128'h0, 3'd4, 28'h0000012, D_E, acc);
    drain();
    check("latency", last_rsp_cyc, acc + L);

    // Back pressure: engine busy with an evict, then six fills back to back.
    for (int i = 0; i < 6; i++)
      send(EVICT, 28'h20 + 28'(i), pat(i), 3'd0, 28'h0, 128'h0, acc);
    drain();
    send(EVICT, 28'h30, pat(9), 3'd0, 28'h0, 128'h0, acc);
    for (int i = 0; i < 6; i++) begin
      send(FILL, 28'h20 + 28'(i), 128'h0, 3'(i), 28'h20 + 28'(i), pat(i), acc);
      if (i == 3) check("ready_full", fm_ready, 1'b0);
    end
    drain();

    // Reserved opcode then idle cycles.
    fm_req_opcode = RSVD;
    @(negedge clk);
    fm_req_opcode = NOP;
    check("err_set", fm_err, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("err_sticky", fm_err, 1'b1);
      check("rsvd_busy",  fm_busy, 1'b0);
    end

    // Reset two cycles after an evict is accepted aborts it.
    send(EVICT, 28'h0000005, D_C, 3'd0, 28'h0, 128'h0, acc);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    next_pop = 0;
    check_reset_state("abort");
    send(FILL, 28'h0000005, 128'h0, 3'd3, 28'h0000005, D_B, acc);
    drain();
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/d_cache_fm_ctrl.md
Name: d_cache_fm_ctrl

Overview:
- Far-memory (FM) controller directly downstream of the data cache in the data-memory subsystem.
- Consumes the cache's miss traffic: line fills and dirty evictions. Holds the backing store for the cacheable region and returns fill responses after a fixed access latency.
- Buffers requests in a small in-order queue and applies back pressure to the cache when the queue is full.

Parameters:
- FM_ADRS_W, 8, line-address bits held; backing store is 2**FM_ADRS_W lines of 128 bits.
- FIFO_DEPTH, 4, request-queue entries (power of 2, >=2).
- FM_LATENCY, 4, cycles from request acceptance to response on an idle controller (>=2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, reset is synchronous and active-high.
- fm_req_opcode  in  2  00 NO_REQ, 01 FILL_REQ, 10 DIRTY_EVICT, 11 reserved.
- fm_req_address  in  28  cache-line address (byte address [31:4]).
- fm_req_data  in  128  evicted line data; valid for DIRTY_EVICT only.
- fm_req_tq_id  in  3  cache transaction-queue id; echoed on the fill response.
- fm_ready  out  1  queue can accept a request this cycle.
- fm_rsp_valid  out  1  fill response valid, single-cycle pulse.
- fm_rsp_address  out  28  line address of the fill.
- fm_rsp_data  out  128  fill line data.
- fm_rsp_tq_id  out  3  id of the originating FILL_REQ.
- fm_busy  out  1  queue non-empty or engine not IDLE.
- fm_err  out  1  sticky flag: a reserved opcode was presented.

Behaviour:
- Acceptance:
  - A request is accepted on a rising edge when fm_req_opcode is 01 or 10 and fm_ready=1.
  - fm_ready = !full. It is combinational from queue state only and does not depend on a same-cycle pop.
  - When fm_ready=0 the cache holds its request stable. The request is not captured.
- Opcode 00: ignored. Opcode 11: not queued; sets fm_err, which stays set until rst.
- Queue: in-order FIFO of {opcode, address, data, tq_id}, with separate rd/wr pointers and a count.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Engine FSM (IDLE, WAIT, DONE):
  - IDLE -> WAIT: queue non-empty. Pop the head into an op register and load the counter with FM_LATENCY-2.
  - WAIT: decrement the counter each cycle; go to DONE when the counter reaches 0.
  - DONE, DIRTY_EVICT: write the line to backing-store index address[FM_ADRS_W-1:0]. No response.
  - DONE, FILL_REQ: read that index and drive fm_rsp_valid=1 for exactly one cycle with the address, data and tq_id.
  - DONE -> IDLE, unconditionally.
- Latency: on an empty queue and idle engine, a request accepted at edge T gives a response registered so that fm_rsp_valid is high in cycle T+FM_LATENCY.
  - Throughput is one operation per FM_LATENCY+1 cycles, fully serialized.
- The cache always accepts responses; there is no response back pressure.
- Ordering: strictly in order. A FILL_REQ queued behind a DIRTY_EVICT to the same line returns the evicted data.
- Address wrap: address bits above FM_ADRS_W are ignored, so aliasing lines share storage. fm_rsp_address still returns the full 28-bit address.
- Reset:
  - Queue emptied, FSM IDLE, counter 0.
  - fm_rsp_valid=0; fm_rsp_address, fm_rsp_data and fm_rsp_tq_id all 0.
  - fm_err=0; fm_ready=1 in the cycle after rst deasserts.
  - Backing-store contents are not reset.
  - rst during WAIT aborts the in-flight operation: no write, no response.
- Bit widths: counter width $clog2(FM_LATENCY) (min 1); queue count width $clog2(FIFO_DEPTH)+1.

Test Plan:
- Evict-then-fill:
  - Stimulus: DIRTY_EVICT addr 0x0000012 data 0xDEADBEEF_01234567_89ABCDEF_CAFEF00D; then FILL_REQ addr 0x0000012, tq_id 5.
  - Response: one fm_rsp_valid pulse with that data and tq_id 5; no response for the evict.
- Latency check, default parameters, idle controller:
  - Stimulus: FILL_REQ accepted at cycle 10.
  - Response: fm_rsp_valid high only in cycle 14.
- Back pressure:
  - Stimulus: present 6 back-to-back FILL_REQs with tq_id 0..5.
  - Response: fm_ready drops after the 4th accepted request; all 6 are eventually accepted; responses come out in tq_id order 0..5, spaced 5 cycles apart.
- Aliasing:
  - Stimulus: DIRTY_EVICT addr 0x0000103 data A; then FILL_REQ addr 0x0000003.
  - Response: returns data A with fm_rsp_address 0x0000003.
- Reserved opcode and no-op:
  - Stimulus: opcode 11 for one cycle, then opcode 00 for 10 cycles.
  - Response: fm_err=1 and stays set; fm_busy=0 throughout; no response.
- Reset mid-operation:
  - Stimulus: assert rst 2 cycles after a DIRTY_EVICT to addr 0x05 is accepted; then FILL_REQ addr 0x05.
  - Response: fm_rsp_valid stays 0 during and after rst until the new fill completes; the fill does not return the aborted evict data.
